// File: rtl/test_status_seq_if.sv
// ---------------------------------------------------------------------------
// test_status_seq_if
// Handshake/result bundle between the grade-entry front end (master) and the
// sequential grade evaluator (slave).
//
// Signals:
//   start              front end -> evaluator   begin a new evaluation
//   grade_valid        front end -> evaluator   grade_in carries a grade
//   grade_in           front end -> evaluator   section grade, GRADE_W bits
//   grade_ready        evaluator -> front end   a grade is accepted this cycle
//   busy               evaluator -> front end   evaluation in progress
//   done               evaluator -> front end   one-cycle pulse, results updated
//   avg_out            evaluator -> front end   registered floor average
//   failed/passed/award_scholarship             registered verdicts
// ---------------------------------------------------------------------------
interface test_status_seq_if #(
    parameter int GRADE_W = 8
);
    logic               start;
    logic               grade_valid;
    logic [GRADE_W-1:0] grade_in;
    logic               grade_ready;
    logic               busy;
    logic               done;
    logic [GRADE_W-1:0] avg_out;
    logic               failed;
    logic               passed;
    logic               award_scholarship;

    modport master (
        output start, grade_valid, grade_in,
        input  grade_ready, busy, done, avg_out, failed, passed, award_scholarship
    );

    modport slave (
        input  start, grade_valid, grade_in,
        output grade_ready, busy, done, avg_out, failed, passed, award_scholarship
    );
endinterface

// File: rtl/test_status_seq.sv
// ---------------------------------------------------------------------------
// test_status_seq
// Sequential grade evaluator. After `start`, collects NUM_SECT section grades
// (one per grade_valid/grade_ready handshake), clamps each to MAX_GRADE,
// accumulates them, then computes the floor average and registers the
// failed / passed / award_scholarship verdicts with a one-cycle `done` pulse.
// Results hold until the next evaluation completes.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of test_status_seq_if (handshake + results)
//
// Optional feature macro: TEST_STATUS_SECT_MIN_EN
//   When defined, any accepted (clamped) grade below SECT_MIN forces
//   failed=1, passed=0, award_scholarship=0 regardless of the average.
//   When undefined, the verdict depends on the average only.
// ---------------------------------------------------------------------------
module test_status_seq #(
    parameter int NUM_SECT     = 4,
    parameter int GRADE_W      = 8,
    parameter int MAX_GRADE    = 100,
    parameter int PASS_THRESH  = 50,
    parameter int SCHOL_THRESH = 85,
    parameter int SECT_MIN     = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    test_status_seq_if.slave  bus
);

    // Sum of NUM_SECT grades each below 2**GRADE_W never overflows this width.
    localparam int SUM_W = GRADE_W + $clog2(NUM_SECT + 1);
    localparam int CNT_W = $clog2(NUM_SECT + 1);

    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(NUM_SECT - 1);
    localparam logic [GRADE_W-1:0] MAX_G    = GRADE_W'(MAX_GRADE);
    localparam logic [SUM_W-1:0]   DIVISOR  = SUM_W'(NUM_SECT);
    localparam logic [SUM_W-1:0]   PASS_T   = SUM_W'(PASS_THRESH);
    localparam logic [SUM_W-1:0]   SCHOL_T  = SUM_W'(SCHOL_THRESH);

    // Elaboration-time parameter sanity checks.
    generate
        if (NUM_SECT < 1) begin : g_chk_num_sect
            $error("test_status_seq: NUM_SECT must be at least 1");
        end
        if (MAX_GRADE >= 2**GRADE_W) begin : g_chk_max_grade
            $error("test_status_seq: MAX_GRADE does not fit in GRADE_W bits");
        end
        if (SECT_MIN >= 2**GRADE_W) begin : g_chk_sect_min
            $error("test_status_seq: SECT_MIN does not fit in GRADE_W bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EVAL    = 2'd2
    } state_t;

    state_t             state_reg;
    logic [SUM_W-1:0]   sum_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               grade_ready_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [GRADE_W-1:0] avg_reg;
    logic               failed_reg;
    logic               passed_reg;
    logic               schol_reg;
`ifdef TEST_STATUS_SECT_MIN_EN
    localparam logic [GRADE_W-1:0] SMIN = GRADE_W'(SECT_MIN);
    logic               min_flag_reg;
    logic               grade_below_min;
`endif

    logic [GRADE_W-1:0] grade_clamped;
    logic               accept;
    logic [SUM_W-1:0]   avg_full;
    logic               verdict_pass;
    logic               verdict_schol;

    always_comb begin
        grade_clamped = (bus.grade_in > MAX_G) ? MAX_G : bus.grade_in;
        // grade_ready_reg is only ever high in COLLECT.
        accept        = bus.grade_valid && grade_ready_reg;
        avg_full      = sum_reg / DIVISOR;
        verdict_pass  = (avg_full >= PASS_T);
`ifdef TEST_STATUS_SECT_MIN_EN
        grade_below_min = (grade_clamped < SMIN);
        verdict_pass    = verdict_pass && !min_flag_reg;
`endif
        verdict_schol = verdict_pass && (avg_full >= SCHOL_T);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            sum_reg         <= '0;
            cnt_reg         <= '0;
            grade_ready_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            avg_reg         <= '0;
            failed_reg      <= 1'b0;
            passed_reg      <= 1'b0;
            schol_reg       <= 1'b0;
`ifdef TEST_STATUS_SECT_MIN_EN
            min_flag_reg    <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg       <= COLLECT;
                        sum_reg         <= '0;
                        cnt_reg         <= '0;
                        grade_ready_reg <= 1'b1;
                        busy_reg        <= 1'b1;
`ifdef TEST_STATUS_SECT_MIN_EN
                        min_flag_reg    <= 1'b0;
`endif
                    end
                end

                COLLECT: begin
                    if (accept) begin
                        sum_reg <= sum_reg + SUM_W'(grade_clamped);
                        cnt_reg <= cnt_reg + 1'b1;
`ifdef TEST_STATUS_SECT_MIN_EN
                        if (grade_below_min) begin
                            min_flag_reg <= 1'b1;
                        end
`endif
                        if (cnt_reg == LAST_IDX) begin
                            state_reg       <= EVAL;
                            grade_ready_reg <= 1'b0;
                        end
                    end
                end

                EVAL: begin
                    // avg_full <= MAX_GRADE, so the truncation is lossless.
                    avg_reg    <= avg_full[GRADE_W-1:0];
                    passed_reg <= verdict_pass;
                    failed_reg <= !verdict_pass;
                    schol_reg  <= verdict_schol;
                    done_reg   <= 1'b1;
                    busy_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end

                default: begin
                    state_reg       <= IDLE;
                    grade_ready_reg <= 1'b0;
                    busy_reg        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grade_ready       = grade_ready_reg;
    assign bus.busy              = busy_reg;
    assign bus.done              = done_reg;
    assign bus.avg_out           = avg_reg;
    assign bus.failed            = failed_reg;
    assign bus.passed            = passed_reg;
    assign bus.award_scholarship = schol_reg;

endmodule

// File: tb/tb_test_status_seq.sv
// ---------------------------------------------------------------------------
// tb_test_status_seq
// Scoreboard bench for test_status_seq: the driver pushes the reference
// model's expected result when an evaluation's last grade is accepted; a
// monitor pops and compares whenever `done` is seen.
// ---------------------------------------------------------------------------
module tb_test_status_seq;

    localparam int NUM_SECT     = 4;
    localparam int GRADE_W      = 8;
    localparam int MAX_GRADE    = 100;
    localparam int PASS_THRESH  = 50;
    localparam int SCHOL_THRESH = 85;
    localparam int SECT_MIN     = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    test_status_seq_if #(.GRADE_W(GRADE_W)) bus ();

    test_status_seq #(
        .NUM_SECT    (NUM_SECT),
        .GRADE_W     (GRADE_W),
        .MAX_GRADE   (MAX_GRADE),
        .PASS_THRESH (PASS_THRESH),
        .SCHOL_THRESH(SCHOL_THRESH),
        .SECT_MIN    (SECT_MIN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int avg;
        bit failed;
        bit passed;
        bit schol;
        int done_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   cur_g[NUM_SECT];
    bit   have_result = 1'b0;
    int   last_avg    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // All outputs packed into one value; zero means everything at reset value.
    function automatic int outs();
        return int'({bus.grade_ready, bus.busy, bus.done, bus.failed,
                     bus.passed, bus.award_scholarship, bus.avg_out});
    endfunction

    // Reference model: evaluation rules applied directly to the grade list.
    function automatic exp_t model();
        exp_t e;
        int   s = 0;
        bit   low = 1'b0;
        for (int i = 0; i < NUM_SECT; i++) begin
            int c;
            c = (cur_g[i] > MAX_GRADE) ? MAX_GRADE : cur_g[i];
            s += c;
            if (c < SECT_MIN) low = 1'b1;
        end
        e.avg    = s / NUM_SECT;
        e.passed = (e.avg >= PASS_THRESH);
`ifdef TEST_STATUS_SECT_MIN_EN
        if (low) e.passed = 1'b0;
`endif
        e.schol    = e.passed && (e.avg >= SCHOL_THRESH);
        e.failed   = !e.passed;
        e.done_cyc = 0;
        return e;
    endfunction

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("done_latency", cyc, mon_e.done_cyc);
                check_eq("avg_out", int'(bus.avg_out), mon_e.avg);
                check_eq("failed", int'(bus.failed), int'(mon_e.failed));
                check_eq("passed", int'(bus.passed), int'(mon_e.passed));
                check_eq("award_scholarship", int'(bus.award_scholarship), int'(mon_e.schol));
                check_eq("fail_pass_exclusive", int'(bus.failed ^ bus.passed), 1);
                $display("eval @%0d: avg=%0d failed=%0b passed=%0b schol=%0b (exp avg=%0d)",
                         cyc, bus.avg_out, bus.failed, bus.passed, bus.award_scholarship, mon_e.avg);
                have_result = 1'b1;
                last_avg    = mon_e.avg;
            end
        end
    end

    // Caller is positioned just after a negedge. Runs one evaluation over
    // cur_g with `gap` idle cycles between grades; optionally pulses start
    // mid-collection, or aborts with reset after `abort_after` accepts.
    task automatic run_eval(input int gap, input bit poke_start, input int abort_after);
        int   waited;
        int   acc_cyc;
        exp_t e;
        bus.start = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.grade_ready && waited < 20);
        bus.start = 1'b0;
        check_eq("start_to_ready", int'(bus.grade_ready), 1);
        if (have_result) check_eq("result_hold", int'(bus.avg_out), last_avg);
        acc_cyc = 0;
        for (int i = 0; i < NUM_SECT; i++) begin
            if (i == abort_after) begin
                rst_n = 1'b0;
                bus.grade_valid = 1'b0;
                #2;
                check_eq("abort_reset_outputs", outs(), 0);
                have_result = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check_eq("abort_idle", outs(), 0);
                $display("aborted after %0d grades", i);
                return;
            end
            bus.grade_valid = 1'b1;
            bus.grade_in    = GRADE_W'(cur_g[i]);
            if (poke_start && i == 1) bus.start = 1'b1;
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            @(negedge clk);
            bus.grade_valid = 1'b0;
            bus.start       = 1'b0;
            if (i < NUM_SECT - 1) begin
                check_eq("ready_in_collect", int'(bus.grade_ready & bus.busy), 1);
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check_eq("ready_in_gap", int'(bus.grade_ready), 1);
                end
            end else begin
                check_eq("not_ready_in_eval", int'({bus.grade_ready, bus.busy}), 1);
            end
        end
        e = model();
        e.done_cyc = acc_cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic set_g(input int a, input int b, input int c, input int d);
        cur_g[0] = a; cur_g[1] = b; cur_g[2] = c; cur_g[3] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start       = 1'b0;
        bus.grade_valid = 1'b0;
        bus.grade_in    = '0;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_after_reset", outs(), 0);

        set_g(10, 20, 30, 30);    run_eval(0, 1'b0, -1);
        set_g(70, 80, 90, 100);   run_eval(0, 1'b0, -1);
        set_g(60, 60, 60, 60);    run_eval(0, 1'b0, -1);
        set_g(40, 50, 60, 10);    run_eval(2, 1'b0, -1);
        set_g(200, 100, 100, 100); run_eval(1, 1'b1, -1);
        // Let the previous done land so the abort starts from a known result.
        repeat (2) @(negedge clk);
        set_g(30, 40, 50, 60);    run_eval(0, 1'b0, 2);
        set_g(30, 40, 50, 60);    run_eval(0, 1'b0, -1);
        set_g(90, 90, 90, 30);    run_eval(0, 1'b0, -1);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < NUM_SECT; i++) begin
                cur_g[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255))
                                                       : int'($urandom_range(30, 110));
            end
            run_eval(int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), -1);
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        check_eq("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
